// File: rtl/ex_stage_if.sv
// rtl/ex_stage_if.sv - ID/EX, WB and EX/MEM signal bundle for the execute stage
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface ex_stage_if;
    logic                   en;
    logic                   flush;
    logic [`DATA_WIDTH-1:0] ex_data_rs1_data;
    logic [`DATA_WIDTH-1:0] ex_data_rs2_data;
    logic [`DATA_WIDTH-1:0] ex_data_imm;
    logic [`DATA_WIDTH-1:0] ex_data_pc;
    logic [4:0]             ex_data_rs1_addr;
    logic [4:0]             ex_data_rs2_addr;
    logic [4:0]             ex_data_rd_addr;
    logic [2:0]             ex_control_alu_code;
    logic [1:0]             ex_control_ALU_a_source;
    logic [1:0]             ex_control_ALU_b_source;
    logic [1:0]             ex_control_Wb_sel;
    logic                   ex_control_wb_en;
    logic [2:0]             ex_control_mem_read;
    logic [2:0]             ex_control_mem_write;
    logic [4:0]             id_rs1_addr;
    logic [4:0]             id_rs2_addr;
    logic [`DATA_WIDTH-1:0] wb_data_wdata;
    logic [4:0]             wb_data_rd_addr;
    logic                   wb_control_wb_en;
    logic                   stall_req;
    logic [`DATA_WIDTH-1:0] mem_data_alu_result;
    logic [`DATA_WIDTH-1:0] mem_data_rs2_data;
    logic [`DATA_WIDTH-1:0] mem_data_pc;
    logic [4:0]             mem_data_rd_addr;
    logic [1:0]             mem_control_Wb_sel;
    logic                   mem_control_wb_en;
    logic [2:0]             mem_control_mem_read;
    logic [2:0]             mem_control_mem_write;

    modport slave (
        input  en, flush,
        input  ex_data_rs1_data, ex_data_rs2_data, ex_data_imm, ex_data_pc,
        input  ex_data_rs1_addr, ex_data_rs2_addr, ex_data_rd_addr,
        input  ex_control_alu_code, ex_control_ALU_a_source, ex_control_ALU_b_source,
        input  ex_control_Wb_sel, ex_control_wb_en, ex_control_mem_read, ex_control_mem_write,
        input  id_rs1_addr, id_rs2_addr,
        input  wb_data_wdata, wb_data_rd_addr, wb_control_wb_en,
        output stall_req,
        output mem_data_alu_result, mem_data_rs2_data, mem_data_pc, mem_data_rd_addr,
        output mem_control_Wb_sel, mem_control_wb_en, mem_control_mem_read, mem_control_mem_write
    );

    modport master (
        output en, flush,
        output ex_data_rs1_data, ex_data_rs2_data, ex_data_imm, ex_data_pc,
        output ex_data_rs1_addr, ex_data_rs2_addr, ex_data_rd_addr,
        output ex_control_alu_code, ex_control_ALU_a_source, ex_control_ALU_b_source,
        output ex_control_Wb_sel, ex_control_wb_en, ex_control_mem_read, ex_control_mem_write,
        output id_rs1_addr, id_rs2_addr,
        output wb_data_wdata, wb_data_rd_addr, wb_control_wb_en,
        input  stall_req,
        input  mem_data_alu_result, mem_data_rs2_data, mem_data_pc, mem_data_rd_addr,
        input  mem_control_Wb_sel, mem_control_wb_en, mem_control_mem_read, mem_control_mem_write
    );
endinterface

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - RV32 execute stage with EX/MEM register; EX_FORWARD_EN enables MEM/WB forwarding
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module ex_stage #(
    parameter int SHAMT_W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    ex_stage_if.slave    bus
);
    localparam int W = `DATA_WIDTH;

    logic [W-1:0] rs1_fwd;
    logic [W-1:0] rs2_fwd;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [W-1:0] alu_result;
    logic         load_use;
    logic         raw_hazard;

    // Does a producer's rd collide with either nonzero source register of the ID instruction?
    function automatic logic id_src_match(input logic [4:0] rd, input logic [4:0] s1, input logic [4:0] s2);
        return ((s1 != 5'd0) && (rd == s1)) || ((s2 != 5'd0) && (rd == s2));
    endfunction

`ifdef EX_FORWARD_EN
    logic mem_fwd_ok;
    assign mem_fwd_ok = bus.mem_control_wb_en && (bus.mem_control_mem_read == 3'd0);

    always_comb begin
        rs1_fwd = bus.ex_data_rs1_data;
        rs2_fwd = bus.ex_data_rs2_data;
        if (bus.ex_data_rs1_addr != 5'd0) begin
            if (mem_fwd_ok && (bus.mem_data_rd_addr == bus.ex_data_rs1_addr))
                rs1_fwd = bus.mem_data_alu_result;
            else if (bus.wb_control_wb_en && (bus.wb_data_rd_addr == bus.ex_data_rs1_addr))
                rs1_fwd = bus.wb_data_wdata;
        end
        if (bus.ex_data_rs2_addr != 5'd0) begin
            if (mem_fwd_ok && (bus.mem_data_rd_addr == bus.ex_data_rs2_addr))
                rs2_fwd = bus.mem_data_alu_result;
            else if (bus.wb_control_wb_en && (bus.wb_data_rd_addr == bus.ex_data_rs2_addr))
                rs2_fwd = bus.wb_data_wdata;
        end
    end

    assign raw_hazard = 1'b0;
`else
    assign rs1_fwd = bus.ex_data_rs1_data;
    assign rs2_fwd = bus.ex_data_rs2_data;

    // Without forwarding, any in-flight producer ahead of WB must drain before ID may proceed.
    assign raw_hazard =
        (bus.ex_control_wb_en  && id_src_match(bus.ex_data_rd_addr,  bus.id_rs1_addr, bus.id_rs2_addr)) ||
        (bus.mem_control_wb_en && id_src_match(bus.mem_data_rd_addr, bus.id_rs1_addr, bus.id_rs2_addr));
`endif

    assign load_use = (bus.ex_control_mem_read != 3'd0) && bus.ex_control_wb_en &&
                      id_src_match(bus.ex_data_rd_addr, bus.id_rs1_addr, bus.id_rs2_addr);

    assign bus.stall_req = load_use || raw_hazard;

    always_comb begin
        op_a = '0;
        case (bus.ex_control_ALU_a_source)
            2'b00:   op_a = rs1_fwd;
            2'b01:   op_a = bus.ex_data_pc;
            default: op_a = '0;
        endcase
    end

    always_comb begin
        op_b = '0;
        case (bus.ex_control_ALU_b_source)
            2'b00:   op_b = rs2_fwd;
            2'b01:   op_b = bus.ex_data_imm;
            2'b10:   op_b = W'(4);
            default: op_b = '0;
        endcase
    end

    always_comb begin
        alu_result = '0;
        case (bus.ex_control_alu_code)
            3'b000: alu_result = op_a + op_b;
            3'b001: alu_result = op_a - op_b;
            3'b010: alu_result = op_a & op_b;
            3'b011: alu_result = op_a | op_b;
            3'b100: alu_result = op_a ^ op_b;
            3'b101: alu_result = op_a << op_b[SHAMT_W-1:0];
            3'b110: alu_result = op_a >> op_b[SHAMT_W-1:0];
            3'b111: alu_result = {{(W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            default: alu_result = '0;
        endcase
    end

    // A flush still loads the datapath so the bubble carries deterministic data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.mem_data_alu_result   <= '0;
            bus.mem_data_rs2_data     <= '0;
            bus.mem_data_pc           <= '0;
            bus.mem_data_rd_addr      <= '0;
            bus.mem_control_Wb_sel    <= '0;
            bus.mem_control_wb_en     <= 1'b0;
            bus.mem_control_mem_read  <= '0;
            bus.mem_control_mem_write <= '0;
        end else if (bus.flush) begin
            bus.mem_data_alu_result   <= alu_result;
            bus.mem_data_rs2_data     <= rs2_fwd;
            bus.mem_data_pc           <= bus.ex_data_pc;
            bus.mem_data_rd_addr      <= bus.ex_data_rd_addr;
            bus.mem_control_Wb_sel    <= '0;
            bus.mem_control_wb_en     <= 1'b0;
            bus.mem_control_mem_read  <= '0;
            bus.mem_control_mem_write <= '0;
        end else if (bus.en) begin
            bus.mem_data_alu_result   <= alu_result;
            bus.mem_data_rs2_data     <= rs2_fwd;
            bus.mem_data_pc           <= bus.ex_data_pc;
            bus.mem_data_rd_addr      <= bus.ex_data_rd_addr;
            bus.mem_control_Wb_sel    <= bus.ex_control_Wb_sel;
            bus.mem_control_wb_en     <= bus.ex_control_wb_en;
            bus.mem_control_mem_read  <= bus.ex_control_mem_read;
            bus.mem_control_mem_write <= bus.ex_control_mem_write;
        end
    end
endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage RV32 pipeline, sitting directly downstream of the ID/EX register and feeding the MEM stage. It selects ALU operands, forwards results from MEM and WB, evaluates the 3-bit ALU operation, and captures the outcome in its EX/MEM register. That register supports hold (stall) and flush (bubble). The block also raises the load-use stall request back to the IF/ID front end.

## Interface
Parameters:
- SHAMT_W, 5: shift-amount width; shifts use operand b[SHAMT_W-1:0].

Ports (data width is `DATA_WIDTH`, 32):
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  EX/MEM register update enable; 0 holds all outputs.
- flush  in  1  load a bubble into EX/MEM on the next edge.
- ex_data_rs1_data, ex_data_rs2_data, ex_data_imm, ex_data_pc  in  `DATA_WIDTH` each  operands from ID/EX.
- ex_data_rs1_addr, ex_data_rs2_addr, ex_data_rd_addr  in  5 each  register addresses from ID/EX.
- ex_control_alu_code  in  3  ALU operation.
- ex_control_ALU_a_source, ex_control_ALU_b_source  in  2 each  operand selects.
- ex_control_Wb_sel  in  2  writeback select, passed through.
- ex_control_wb_en  in  1  register write enable.
- ex_control_mem_read, ex_control_mem_write  in  3 each  load/store size codes; 0 means none.
- id_rs1_addr, id_rs2_addr  in  5 each  source registers of the instruction now in ID.
- wb_data_wdata  in  `DATA_WIDTH`  value being written back.
- wb_data_rd_addr  in  5  writeback destination register.
- wb_control_wb_en  in  1  writeback enable.
- stall_req  out  1  combinational hazard stall to PC, IF/ID and ID/EX.
- mem_data_alu_result, mem_data_rs2_data, mem_data_pc  out  `DATA_WIDTH` each  registered.
- mem_data_rd_addr  out  5  registered.
- mem_control_Wb_sel  out  2  registered.
- mem_control_wb_en  out  1  registered.
- mem_control_mem_read, mem_control_mem_write  out  3 each  registered.

## Operation
- Operand a by ALU_a_source:
  - 00: forwarded rs1.
  - 01: pc.
  - 10 and 11: zero.
- Operand b by ALU_b_source:
  - 00: forwarded rs2.
  - 01: imm.
  - 10: constant 4.
  - 11: zero.
- alu_code:
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR.
  - 101 SLL and 110 SRL (logical), shift amount b[4:0].
  - 111 SLT: signed compare, result 32'h1 or 32'h0.
  - Arithmetic is modulo 2^32; overflow is ignored.
- Forwarding (when compiled in), evaluated separately for rs1 and rs2:
  - Source address 0 is never forwarded.
  - First priority: EX/MEM match, when mem_control_wb_en=1, mem_data_rd_addr equals the source address, and mem_control_mem_read=0. The forwarded value is mem_data_alu_result.
  - Second priority: WB match, when wb_control_wb_en=1 and wb_data_rd_addr equals the source address. The forwarded value is wb_data_wdata.
  - Otherwise the ID/EX value is used.
- The forwarded rs2 value, not raw rs2, is what is registered into mem_data_rs2_data (store data).
- stall_req is asserted when ex_control_mem_read≠0, ex_control_wb_en=1, ex_data_rd_addr≠0, and ex_data_rd_addr equals id_rs1_addr or id_rs2_addr.
- Handling of a stall is upstream's job: upstream holds PC and IF/ID and injects an all-zero-control bubble into ID/EX. This block keeps en=1 during a stall.
- EX/MEM register update priority on each rising edge:
  - rst_n=0: all outputs go to 0.
  - else flush=1: all control outputs (wb_en, mem_read, mem_write, Wb_sel) go to 0. Data outputs load the current values; they are don't-care but must be deterministic.
  - else en=1: load all computed values.
  - else: hold.

## Timing
- Datapath latency is one cycle: ID/EX values present in cycle N appear on mem_* outputs after edge N+1.
- stall_req is purely combinational: same cycle as its inputs, with no registered delay.
- Every output resets to 0, with reset effective at the next edge.
- Reset asserted mid-stream discards the in-flight instruction; the first edge after release loads normally.
- flush and en=0 asserted together: flush wins.
- rst_n=0 overrides both flush and en.
- While en=0, the outputs feeding forwarding hold, so forwarding stays consistent with the held instruction.

## Configuration
- EX_FORWARD_EN:
  - Defined: forwarding operates as described in Operation.
  - Undefined: operands always come from ID/EX, and stall_req is additionally asserted on any RAW hazard with a nonzero source address:
    - the EX instruction (ex_control_wb_en=1 and ex_data_rd_addr matches id_rs1_addr or id_rs2_addr), or
    - the EX/MEM instruction (mem_control_wb_en=1 and mem_data_rd_addr matches id_rs1_addr or id_rs2_addr).
  - The register file is write-first, so a WB-stage producer needs no stall in either configuration.

## Test plan
- ADD a=5 (rs1, a_src=00), b=imm 7 (b_src=01), wb_en=1, rd=3 -> one edge later alu_result=12, rd_addr=3, wb_en=1.
- SUB 3-5 -> 32'hFFFF_FFFE; SLT -1<1 -> 1; SRL 32'h8000_0000 by 31 -> 1; SLL 1 by 33 uses b[4:0]=1 -> 2.
- Back-to-back RAW: the first instruction writes x5=10 into EX/MEM; the next instruction reads rs1=x5 while ID/EX supplies stale 0 -> result uses 10. Simultaneous WB x5=99 loses to the MEM-stage value. Reading x0 is never forwarded.
- Load-use: EX holds mem_read=3'b010 with rd=4, id_rs2_addr=4 -> stall_req=1 in the same cycle. rd=0 -> stall_req=0.
- Flush and en=0 asserted together -> mem_control_wb_en, mem_read and mem_write all 0 on the next edge. A later cycle with en=0 and flush=0 holds all outputs unchanged.
- rst_n=0 for one edge mid-stream -> all mem_* outputs are 0. With EX_FORWARD_EN undefined, the RAW case in scenario 3 gives stall_req=1.
